// File: rtl/cisr_pkg.sv
// Shared definitions for the CISR row-accumulator channel: default widths
// and the accumulator state encoding.
package cisr_pkg;

    localparam int CISR_ROW_W  = 5;
    localparam int CISR_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2
    } acc_state_e;

endpackage

// File: rtl/cisr_result_fifo.sv
// Synchronous first-word-fall-through FIFO holding {rowID, sum} results.
// Full and empty are registered; DEPTH must be a power of two so the
// pointers wrap naturally.
module cisr_result_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, empty_q;
    logic             wr_en, rd_en;

    // A push while full is only taken when a pop frees the head slot this cycle.
    always_comb begin
        wr_en   = push_i & (!full_q | pop_i);
        rd_en   = pop_i & !empty_q;
        count_d = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage array carries no reset; only valid entries are ever read.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer, occupancy and flag registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/cisr_row_accumulator.sv
// Per-channel row accumulator: sums consecutive products sharing a rowID and
// emits one (rowID, sum) per non-empty row through a small result FIFO.
module cisr_row_accumulator
    import cisr_pkg::*;
#(
    parameter int ROW_W    = CISR_ROW_W,
    parameter int DATA_W   = CISR_DATA_W,
    parameter int FIFO_DEP = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ROW_W-1:0]         in_rowID,
    input  logic signed [DATA_W-1:0] in_product,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ROW_W-1:0]         out_rowID,
    output logic signed [DATA_W-1:0] out_sum,
    output logic                     err_order,
    output logic                     busy
);

    localparam int ENTRY_W = ROW_W + DATA_W;

    // Sums wrap modulo 2^DATA_W; no saturation is applied.
    function automatic logic signed [DATA_W-1:0] wrap_add(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return a + b;
    endfunction

    acc_state_e                state_q;
    logic [ROW_W-1:0]          cur_row_q;
    logic signed [DATA_W-1:0]  acc_q;
    logic                      err_q;

    logic                      fifo_full, fifo_empty;
    logic                      fifo_push;
    logic [ENTRY_W-1:0]        fifo_rdata;
    logic                      accept;
    logic                      same_row;

    assign in_ready  = reset & (state_q != FLUSH) & !fifo_full;
    assign accept    = in_valid & in_ready;
    assign same_row  = (in_rowID == cur_row_q);

    // The open row is closed either by a row change in ACCUM or by the FLUSH
    // state once the FIFO has room; both push the current (row, acc) pair.
    assign fifo_push = ((state_q == ACCUM) & accept & !same_row)
                     | ((state_q == FLUSH) & !fifo_full);

    // Accumulator FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cur_row_q <= '0;
            acc_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cur_row_q <= in_rowID;
                        acc_q     <= in_product;
                        state_q   <= in_last ? FLUSH : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (same_row) begin
                            acc_q <= wrap_add(acc_q, in_product);
                        end else begin
                            cur_row_q <= in_rowID;
                            acc_q     <= in_product;
                        end
                        if (in_rowID < cur_row_q) err_q <= 1'b1;
                        state_q <= in_last ? FLUSH : ACCUM;
                    end
                end
                FLUSH: begin
                    if (!fifo_full) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    cisr_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEP)
    ) u_result_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (fifo_push),
        .wdata_i ({cur_row_q, acc_q}),
        .pop_i   (out_ready),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_valid = reset & !fifo_empty;
    assign out_rowID = fifo_rdata[ENTRY_W-1 -: ROW_W];
    assign out_sum   = fifo_rdata[DATA_W-1:0];
    assign err_order = err_q;
    assign busy      = reset & ((state_q != IDLE) | !fifo_empty);

endmodule

// File: tb/tb_cisr_row_accumulator.sv
// Directed bench for cisr_row_accumulator with a row-grouping reference model
// and a per-cycle result/error scoreboard.
module tb_cisr_row_accumulator;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [4:0]         in_rowID;
    logic signed [31:0] in_product;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [4:0]         out_rowID;
    logic signed [31:0] out_sum;
    logic               err_order;
    logic               busy;

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;

    typedef struct {
        logic [4:0]  row;
        logic [31:0] sum;
    } res_t;

    res_t exp_q[$];
    res_t got_q[$];

    // Reference model: group consecutive beats of a matrix by rowID.
    bit          m_open = 1'b0;
    logic [4:0]  m_row  = '0;
    logic [31:0] m_sum  = '0;
    bit          m_err  = 1'b0;

    always #5 clk = ~clk;

    cisr_row_accumulator dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rowID   (in_rowID),
        .in_product (in_product),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rowID  (out_rowID),
        .out_sum    (out_sum),
        .err_order  (err_order),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    task automatic model_beat(input logic [4:0] row, input logic [31:0] p, input bit last);
        if (m_open && row < m_row) m_err = 1'b1;
        if (m_open && row == m_row) begin
            m_sum = m_sum + p;
        end else begin
            if (m_open) exp_q.push_back('{m_row, m_sum});
            m_row  = row;
            m_sum  = p;
            m_open = 1'b1;
        end
        if (last) begin
            exp_q.push_back('{m_row, m_sum});
            m_open = 1'b0;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_open = 1'b0;
        m_err  = 1'b0;
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input logic [4:0] row, input logic [31:0] p, input bit last);
        int n;
        in_valid   = 1'b1;
        in_rowID   = row;
        in_product = p;
        in_last    = last;
        n = 0;
        while (!in_ready && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) begin
            fail_now("send_accept");
        end else begin
            @(posedge clk); #1;
            model_beat(row, p, last);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) fail_now(name);
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_got(input int idx, input logic [4:0] row, input logic [31:0] sum);
        if (idx < got_q.size()) begin
            chk($sformatf("got%0d_row", idx), got_q[idx].row, row);
            chk($sformatf("got%0d_sum", idx), got_q[idx].sum, sum);
        end else begin
            checks++;
            failures++;
            $display("FAIL got%0d_present actual=missing required=row %0d sum %0h", idx, row, sum);
        end
    endtask

    task automatic run_test1();
        got_q.delete();
        send(5'd0, 32'd3, 1'b0);
        send(5'd0, 32'd4, 1'b0);
        send(5'd1, 32'd5, 1'b0);
        send(5'd1, -32'sd2, 1'b1);
        wait_idle("t1_idle");
        chk("t1_count", got_q.size(), 2);
        check_got(0, 5'd0, 32'd7);
        check_got(1, 5'd1, 32'd3);
        chk("t1_busy", busy, 1'b0);
    endtask

    // Scoreboard: every handshake result and the sticky error flag, each cycle.
    always @(negedge clk) begin
        if (started && reset) begin
            chk("err_order", err_order, m_err);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result actual=row %0d sum %0h required=none",
                             out_rowID, out_sum);
                end else begin
                    chk("out_rowID", out_rowID, exp_q[0].row);
                    chk("out_sum", out_sum, exp_q[0].sum);
                    void'(exp_q.pop_front());
                end
                got_q.push_back('{out_rowID, out_sum});
            end
        end
    end

    initial begin
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_rowID   = '0;
        in_product = '0;
        in_last    = 1'b0;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_err", err_order, 1'b0);
        reset   = 1'b1;
        started = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", in_ready, 1'b1);

        // Two rows summed and emitted in order.
        run_test1();

        // Single-beat matrix: one FLUSH cycle, result the cycle after the push.
        got_q.delete();
        send(5'd7, 32'd9, 1'b1);
        chk("t2_flush_busy", busy, 1'b1);
        chk("t2_flush_in_ready", in_ready, 1'b0);
        chk("t2_flush_out_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        chk("t2_out_valid", out_valid, 1'b1);
        chk("t2_out_row", out_rowID, 32'd7);
        chk("t2_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        chk("t2_drained_valid", out_valid, 1'b0);
        chk("t2_drained_busy", busy, 1'b0);
        check_got(0, 5'd7, 32'd9);

        // Backpressure: FIFO fills after four results, nothing lost.
        got_q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(5'(i), 32'(i * 10 + 1), 1'b0);
        chk("t3_in_ready_full", in_ready, 1'b0);
        chk("t3_out_valid", out_valid, 1'b1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("t3_still_blocked", in_ready, 1'b0);
        chk("t3_none_popped", got_q.size(), 0);
        out_ready = 1'b1;
        send(5'd5, 32'd51, 1'b1);
        wait_idle("t3_idle");
        chk("t3_count", got_q.size(), 6);
        for (int i = 0; i < 6; i++) check_got(i, 5'(i), 32'(i * 10 + 1));

        // Two's-complement wrap of the sum.
        got_q.delete();
        send(5'd2, 32'h7FFF_FFFF, 1'b0);
        send(5'd2, 32'd1, 1'b1);
        wait_idle("t4_idle");
        check_got(0, 5'd2, 32'h8000_0000);

        // Descending rowID raises the sticky error but results still flow.
        got_q.delete();
        send(5'd4, 32'd1, 1'b0);
        send(5'd3, 32'd1, 1'b1);
        wait_idle("t5_idle");
        chk("t5_err", err_order, 1'b1);
        check_got(0, 5'd4, 32'd1);
        check_got(1, 5'd3, 32'd1);
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("t5_err_sticky", err_order, 1'b1);

        // Reset with a row open and two results queued discards everything.
        out_ready = 1'b0;
        send(5'd0, 32'd1, 1'b0);
        send(5'd1, 32'd2, 1'b0);
        send(5'd2, 32'd3, 1'b0);
        chk("t6_pre_busy", busy, 1'b1);
        chk("t6_pre_out_valid", out_valid, 1'b1);
        reset = 1'b0;
        model_reset();
        #1;
        chk("t6_rst_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        chk("t6_out_valid", out_valid, 1'b0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_err", err_order, 1'b0);
        reset     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t6_release_out_valid", out_valid, 1'b0);
        chk("t6_release_busy", busy, 1'b0);
        chk("t6_release_in_ready", in_ready, 1'b1);
        run_test1();

        chk("leftover_expected", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
